mem_wb_buf: RTL and testbench

Parametrised, elastic buffer between the memory stage and writeback of the br32 pipeline, replacing the plain MEM/WB signal bundle with a DEPTH-entry FIFO of packed memory-stage results. It adds valid/ready handshaking, optional bubble dropping, and trap serialisation (one scall/eret/udf in flight). It also provides register-file and condition-register forwarding from the youngest matching buffered entry.

---
 rtl/mem_wb_pkg.sv | 40 ++++
 rtl/mem_wb_fwd.sv | 55 +++++
 rtl/mem_wb_buf.sv | 151 +++++++++++++++
 tb/tb_mem_wb_buf.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// ============================================================================
// Module      : mem_wb_pkg
// Description : Shared types and helpers for the br32 MEM/WB elastic buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_wb_pkg;

    localparam int XLEN_BR32 = 32;
    localparam int RW_BR32   = 5;

    // Packed memory-stage result; field order fixes the bit layout.
    typedef struct packed {
        logic [XLEN_BR32-1:0] pc;
        logic [XLEN_BR32-1:0] nextpc;
        logic [XLEN_BR32-1:0] res;
        logic [RW_BR32-1:0]   rd;
        logic                 w_rd;
        logic [1:0]           cmp_res;
        logic                 w_cr;
        logic [XLEN_BR32-1:0] op3;
        logic [XLEN_BR32-1:0] alu_res;
        logic                 mtsr;
        logic                 scall;
        logic                 eret;
        logic                 udf;
        logic                 bubble;
    } mem_out_t;

    // Pointer width for a given depth, never narrower than one bit.
    function automatic int depth_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int DEPTH_W = depth_w(2);

endpackage

`default_nettype wire

// File: rtl/mem_wb_fwd.sv
// ============================================================================
// Module      : mem_wb_fwd
// Description : Youngest-first register / condition-register forwarding scan.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_fwd #(
    parameter int DEPTH = 2,
    parameter int PW    = 1,
    parameter int CW    = 2,
    parameter int XLEN  = 32,
    parameter int RW    = 5
) (
    input  logic [RW-1:0]   rd      [DEPTH],
    input  logic            w_rd    [DEPTH],
    input  logic [XLEN-1:0] res     [DEPTH],
    input  logic            w_cr    [DEPTH],
    input  logic [1:0]      cmp_res [DEPTH],
    input  logic [PW-1:0]   rd_ptr,
    input  logic [CW-1:0]   count,
    input  logic [RW-1:0]   rs,
    output logic            hit,
    output logic [XLEN-1:0] data,
    output logic            cr_hit,
    output logic [1:0]      cr
);

    logic [PW-1:0] w_idx;

    // Walk oldest to youngest; later matches overwrite, so the youngest wins.
    always_comb begin
        hit    = 1'b0;
        data   = '0;
        cr_hit = 1'b0;
        cr     = '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = rd_ptr + PW'(k);
            if (CW'(k) < count) begin
                if (w_rd[w_idx] && (rd[w_idx] == rs) && (rs != '0)) begin
                    hit  = 1'b1;
                    data = res[w_idx];
                end
                if (w_cr[w_idx]) begin
                    cr_hit = 1'b1;
                    cr     = cmp_res[w_idx];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_wb_buf.sv
// ============================================================================
// Module      : mem_wb_buf
// Description : Elastic MEM->WB FIFO with bubble dropping, trap serialisation
//               and register / CR forwarding from buffered entries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_buf
    import mem_wb_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NREG        = 32,
    parameter int DEPTH       = 2,
    parameter bit DROP_BUBBLE = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  mem_out_t                   in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output mem_out_t                   out_data,
    input  logic                       flush,
    input  logic [$clog2(NREG)-1:0]    fwd_rs,
    output logic                       fwd_hit,
    output logic [XLEN-1:0]            fwd_data,
    output logic                       fwd_cr_hit,
    output logic [1:0]                 fwd_cr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = depth_w(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = $clog2(NREG);

    mem_out_t       r_mem [DEPTH];
    mem_out_t       r_last_head;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW-1:0]  r_wr_ptr;
    logic [CW-1:0]  r_count;
    logic           r_trap_pend;

    mem_out_t       w_head;
    logic           w_enq;
    logic           w_deq;
    logic           w_in_trap;
    logic           w_head_trap;

    assign w_head      = r_mem[r_rd_ptr];
    assign in_ready    = (r_count < CW'(DEPTH)) && !r_trap_pend;
    assign out_valid   = (r_count != '0);
    assign count       = r_count;
    assign w_in_trap   = in_data.scall | in_data.eret | in_data.udf;
    assign w_head_trap = w_head.scall | w_head.eret | w_head.udf;
    // A dropped bubble is still handshaken but never occupies a slot.
    assign w_enq       = in_valid && in_ready && !flush && !(DROP_BUBBLE && in_data.bubble);
    assign w_deq       = out_valid && out_ready;

    always_comb begin
        out_data        = r_last_head;
        out_data.bubble = 1'b1;
        if (out_valid) begin
            out_data = w_head;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_last_head <= '0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_trap_pend <= 1'b0;
        end else begin
            if (w_deq) begin
                r_last_head <= w_head;
            end
            if (flush) begin
                r_rd_ptr    <= '0;
                r_wr_ptr    <= '0;
                r_count     <= '0;
                r_trap_pend <= 1'b0;
            end else begin
                if (w_enq) begin
                    r_mem[r_wr_ptr] <= in_data;
                    r_wr_ptr        <= r_wr_ptr + PW'(1);
                end
                if (w_deq) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                case ({w_enq, w_deq})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
                // While a trap is pending no further enqueue is possible,
                // so the trap entry is the only one that can clear it.
                if (w_enq && w_in_trap) begin
                    r_trap_pend <= 1'b1;
                end else if (w_deq && w_head_trap) begin
                    r_trap_pend <= 1'b0;
                end
            end
        end
    end

    logic [RW-1:0]   w_f_rd      [DEPTH];
    logic            w_f_w_rd    [DEPTH];
    logic [XLEN-1:0] w_f_res     [DEPTH];
    logic            w_f_w_cr    [DEPTH];
    logic [1:0]      w_f_cmp_res [DEPTH];

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_fwd_fields
            assign w_f_rd[g]      = r_mem[g].rd;
            assign w_f_w_rd[g]    = r_mem[g].w_rd;
            assign w_f_res[g]     = r_mem[g].res;
            assign w_f_w_cr[g]    = r_mem[g].w_cr;
            assign w_f_cmp_res[g] = r_mem[g].cmp_res;
        end
    endgenerate

    mem_wb_fwd #(
        .DEPTH (DEPTH),
        .PW    (PW),
        .CW    (CW),
        .XLEN  (XLEN),
        .RW    (RW)
    ) u_fwd (
        .rd      (w_f_rd),
        .w_rd    (w_f_w_rd),
        .res     (w_f_res),
        .w_cr    (w_f_w_cr),
        .cmp_res (w_f_cmp_res),
        .rd_ptr  (r_rd_ptr),
        .count   (r_count),
        .rs      (fwd_rs),
        .hit     (fwd_hit),
        .data    (fwd_data),
        .cr_hit  (fwd_cr_hit),
        .cr      (fwd_cr)
    );

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_buf.sv
// ============================================================================
// Module      : tb_mem_wb_buf
// Description : Directed and random checks of mem_wb_buf against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_buf;
    import mem_wb_pkg::*;

    localparam int DEPTH = 2;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    mem_out_t       in_data;
    logic           out_valid;
    logic           out_ready;
    mem_out_t       out_data;
    logic           flush;
    logic [4:0]     fwd_rs;
    logic           fwd_hit;
    logic [31:0]    fwd_data;
    logic           fwd_cr_hit;
    logic [1:0]     fwd_cr;
    logic [1:0]     count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: FIFO contents, pending trap, last consumed head.
    mem_out_t q[$];
    bit       tp;
    mem_out_t last;

    mem_wb_buf #(
        .XLEN        (32),
        .NREG        (32),
        .DEPTH       (DEPTH),
        .DROP_BUBBLE (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush      (flush),
        .fwd_rs     (fwd_rs),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data),
        .fwd_cr_hit (fwd_cr_hit),
        .fwd_cr     (fwd_cr),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic mem_out_t mk(input logic [31:0] res, input logic [4:0] rd, input logic wrd);
        mem_out_t e;
        e      = '0;
        e.res  = res;
        e.pc   = res << 2;
        e.rd   = rd;
        e.w_rd = wrd;
        return e;
    endfunction

    function automatic mem_out_t rnd();
        mem_out_t e;
        int t;
        e         = '0;
        e.pc      = $urandom;
        e.nextpc  = $urandom;
        e.res     = $urandom;
        e.op3     = $urandom;
        e.alu_res = $urandom;
        e.rd      = 5'($urandom_range(0, 3));
        e.w_rd    = 1'($urandom_range(0, 1));
        e.cmp_res = 2'($urandom_range(0, 3));
        e.w_cr    = ($urandom_range(0, 3) == 0);
        e.mtsr    = 1'($urandom_range(0, 1));
        t         = $urandom_range(0, 11);
        e.scall   = (t == 0);
        e.eret    = (t == 1);
        e.udf     = (t == 2);
        e.bubble  = (t > 2) && ($urandom_range(0, 3) == 0);
        return e;
    endfunction

    // One clock: drive, compare every output with the model, advance the model.
    task automatic step(input logic v, input logic ordy, input logic fl,
                        input mem_out_t d, input logic [4:0] rs);
        mem_out_t    e_out;
        logic        e_hit, e_crh, e_rdy;
        logic [31:0] e_fd;
        logic [1:0]  e_cr;
        bit          dq, ac;
        mem_out_t    h;
        in_valid  = v;
        out_ready = ordy;
        flush     = fl;
        in_data   = d;
        fwd_rs    = rs;
        #4;
        e_rdy = (q.size() < DEPTH) && !tp;
        if (q.size() > 0) begin
            e_out = q[0];
        end else begin
            e_out        = last;
            e_out.bubble = 1'b1;
        end
        e_hit = 0; e_fd = 0; e_crh = 0; e_cr = 0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (!e_hit && q[i].w_rd && q[i].rd == rs && rs != 0) begin
                e_hit = 1;
                e_fd  = q[i].res;
            end
            if (!e_crh && q[i].w_cr) begin
                e_crh = 1;
                e_cr  = q[i].cmp_res;
            end
        end
        check("count", count, q.size());
        check("in_ready", in_ready, e_rdy);
        check("out_valid", out_valid, q.size() != 0);
        check("out_data", out_data, e_out);
        check("fwd_hit", fwd_hit, e_hit);
        if (e_hit) check("fwd_data", fwd_data, e_fd);
        check("fwd_cr_hit", fwd_cr_hit, e_crh);
        if (e_crh) check("fwd_cr", fwd_cr, e_cr);
        dq = (q.size() > 0) && ordy;
        ac = v && e_rdy && !fl;
        if (dq) begin
            h    = q.pop_front();
            last = h;
            if (h.scall || h.eret || h.udf) tp = 0;
        end
        if (fl) begin
            q.delete();
            tp = 0;
        end else if (ac && !d.bubble) begin
            q.push_back(d);
            if (d.scall || d.eret || d.udf) tp = 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        mem_out_t e;
        mem_out_t z;
        z = '0;
        rst_n = 1'b0; in_valid = 0; out_ready = 0; flush = 0; in_data = '0; fwd_rs = 0;
        tp = 0; last = '0;
        #12;
        e = '0; e.bubble = 1'b1;
        check("rst_count", count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_fwd_hit", fwd_hit, 0);
        check("rst_fwd_cr_hit", fwd_cr_hit, 0);
        check("rst_out_data", out_data, e);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back stream with out_ready held high.
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, mk(32'h10 + i, 0, 0), 0);
            check("t1_res", out_data.res, 32'h10 + i);
            check("t1_rdy", in_ready, 1);
        end
        step(0, 1, 0, z, 0);

        // Fill with output stalled, then release and confirm order.
        step(1, 0, 0, mk(32'h10, 0, 0), 0);
        step(1, 0, 0, mk(32'h11, 0, 0), 0);
        check("t2_count", count, 2);
        check("t2_rdy", in_ready, 0);
        step(1, 0, 0, mk(32'h12, 0, 0), 0);
        check("t2_stall", count, 2);
        check("t2_head0", out_data.res, 32'h10);
        step(1, 1, 0, mk(32'h12, 0, 0), 0);
        check("t2_head1", out_data.res, 32'h11);
        step(1, 1, 0, mk(32'h12, 0, 0), 0);
        check("t2_head2", out_data.res, 32'h12);
        step(0, 1, 0, z, 0);

        // Youngest-match forwarding and rd=0 exclusion.
        step(1, 0, 0, mk(32'hA, 5, 1), 0);
        step(1, 0, 0, mk(32'hB, 5, 1), 0);
        step(0, 0, 0, z, 5);
        check("t3_hit", fwd_hit, 1);
        check("t3_data", fwd_data, 32'hB);
        step(0, 1, 0, z, 5);
        step(0, 1, 0, z, 5);
        step(1, 0, 0, mk(32'hC, 0, 1), 0);
        step(0, 0, 0, z, 0);
        check("t3_rd0", fwd_hit, 0);
        step(0, 1, 0, z, 0);

        // Trap serialisation.
        e = mk(32'h55, 1, 1); e.udf = 1'b1;
        step(1, 0, 0, e, 0);
        check("t4_blocked", in_ready, 0);
        step(1, 0, 0, mk(32'h56, 0, 0), 0);
        check("t4_still", in_ready, 0);
        step(0, 1, 0, z, 0);
        check("t4_back", in_ready, 1);

        // Bubble dropping.
        e = mk(32'h1F, 0, 0); e.bubble = 1'b1;
        step(1, 0, 0, e, 0);
        check("t5_drop", count, 0);
        step(1, 0, 0, mk(32'h20, 0, 0), 0);
        check("t5_count", count, 1);
        check("t5_res", out_data.res, 32'h20);
        step(0, 1, 0, z, 0);

        // Flush while full, with a trap pending and an incoming entry.
        step(1, 0, 0, mk(32'h30, 0, 0), 0);
        e = mk(32'h31, 0, 0); e.eret = 1'b1;
        step(1, 0, 0, e, 0);
        step(1, 0, 1, mk(32'h99, 0, 0), 0);
        check("t6_count", count, 0);
        check("t6_valid", out_valid, 0);
        check("t6_rdy", in_ready, 1);
        step(0, 0, 0, z, 0);
        check("t6_nodrop", out_valid, 0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 31) == 0, rnd(), 5'($urandom_range(0, 3)));
        end

        // Asynchronous reset mid-operation.
        step(1, 0, 0, mk(32'h40, 2, 1), 0);
        step(1, 0, 0, mk(32'h41, 2, 1), 0);
        in_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_rdy", in_ready, 1);
        q.delete(); tp = 0; last = '0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        step(0, 0, 0, z, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
